// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush/forwarding control for a five-stage MIPS pipeline,
// plus a data-memory wait FSM with timeout and stall/flush performance counters.
module hazard_controller #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RsE,
    input  logic [4:0]  RtE,
    input  logic [4:0]  WriteRegE,
    input  logic [4:0]  WriteRegM,
    input  logic [4:0]  WriteRegW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemtoRegE,
    input  logic        MemtoRegM,
    input  logic        BranchD,
    input  logic        PCSrcD,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MemError,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCycles
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          memstall;
    logic          timeout_hit;
    logic          lwstall;
    logic          branchstall;

    // Forwarding selection: M stage has priority over W; register 0 never forwards.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RsE != 5'd0 && RegWriteM && RsE == WriteRegM)
            ForwardAE = 2'b10;
        else if (RsE != 5'd0 && RegWriteW && RsE == WriteRegW)
            ForwardAE = 2'b01;
        if (RtE != 5'd0 && RegWriteM && RtE == WriteRegM)
            ForwardBE = 2'b10;
        else if (RtE != 5'd0 && RegWriteW && RtE == WriteRegW)
            ForwardBE = 2'b01;
        ForwardAD = (RsD != 5'd0) && RegWriteM && (RsD == WriteRegM);
        ForwardBD = (RtD != 5'd0) && RegWriteM && (RtD == WriteRegM);
    end

    // Load-use and branch-compare data hazards detected in Decode.
    always_comb begin
        lwstall     = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
        branchstall = BranchD &&
                      ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                       (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
    end

    // Memory wait FSM next state; cnt counts cycles already spent waiting.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        memstall    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (MemReqM && !MemReadyM) begin
                    memstall   = 1'b1;
                    state_next = S_WAIT;
                    cnt_next   = CW'(1);
                end
            end
            S_WAIT: begin
                if (!MemReqM || MemReadyM) begin
                    state_next = S_IDLE;
                end else if (cnt == CW'(MEM_TIMEOUT)) begin
                    // Abort: the access leaves M unfinished and the error is latched.
                    timeout_hit = 1'b1;
                    state_next  = S_IDLE;
                end else begin
                    memstall = 1'b1;
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Stall/flush outputs: a memory freeze overrides every other hazard.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (memstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lwstall || branchstall;
            StallD = lwstall || branchstall;
            FlushE = lwstall || branchstall;
            FlushD = PCSrcD && !(lwstall || branchstall);
        end
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Sticky timeout error and wrapping performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MemError    <= 1'b0;
            StallCycles <= 32'd0;
            FlushCycles <= 32'd0;
        end else begin
            if (timeout_hit)
                MemError <= 1'b1;
            if (StallF)
                StallCycles <= StallCycles + 32'd1;
            if (FlushE || FlushD)
                FlushCycles <= FlushCycles + 32'd1;
        end
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing unit for the five-stage MIPS pipeline. It drives the stall (active-high, fed to each stage register's nEN) and flush (fed to CLR) controls of the F/D/E/M/W pipeline registers, and selects the forwarding paths. It also supervises the data-memory handshake through a small wait FSM with a timeout, and keeps stall/flush performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 16, maximum wait cycles for a data-memory access before it is aborted (2..255).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears FSM, counters, MemError
- RsD, RtD  in  5  source registers in Decode
- RsE, RtE  in  5  source registers in Execute
- WriteRegE, WriteRegM, WriteRegW  in  5  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  in  1  destination write enables
- MemtoRegE, MemtoRegM  in  1  load in E / M
- BranchD  in  1  branch in Decode (compare done in D)
- PCSrcD  in  1  taken branch or jump resolved in D
- MemReqM  in  1  load or store in Memory stage
- MemReadyM  in  1  data memory completes access this cycle
- StallF, StallD, StallE, StallM  out  1  hold stage register
- FlushD, FlushE, FlushW  out  1  clear stage register (bubble)
- ForwardAD, ForwardBD  out  1  forward ALUOutM to D comparator
- ForwardAE, ForwardBE  out  2  00 regfile, 10 ALUOutM, 01 ResultW
- MemError  out  1  sticky, a memory access timed out
- StallCycles, FlushCycles  out  32  performance counters

## Operation
- Forwarding E (per operand, Rs shown): 10 if RsE!=0 & RegWriteM & RsE==WriteRegM; else 01 if RsE!=0 & RegWriteW & RsE==WriteRegW; else 00. M has priority over W.
- Forwarding D: ForwardAD = RsD!=0 & RegWriteM & RsD==WriteRegM; same for Rt/ForwardBD.
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- branchstall = BranchD & ((RegWriteE & (WriteRegE==RsD | WriteRegE==RtD)) | (MemtoRegM & (WriteRegM==RsD | WriteRegM==RtD))).
- memstall: see FSM; while memstall=1, StallF=StallD=StallE=StallM=1, FlushW=1, FlushE=0, FlushD=0 (freeze wins over everything).
- Otherwise: StallF=StallD=lwstall|branchstall; FlushE=lwstall|branchstall; StallE=StallM=0; FlushW=0; FlushD=PCSrcD & !StallD.
- Memory FSM states IDLE, WAIT; wait counter cnt (width clog2(MEM_TIMEOUT+1)).
  - IDLE: memstall = MemReqM & !MemReadyM. If so, go WAIT, cnt<=1.
  - WAIT: if MemReadyM: memstall=0, go IDLE. Else if cnt==MEM_TIMEOUT: memstall=0 (abort; the instruction leaves M), MemError<=1, go IDLE. Else memstall=1, cnt<=cnt+1.
  - WAIT with MemReqM=0 (illegal): go IDLE, memstall=0.
- StallCycles increments every cycle StallF=1; FlushCycles every cycle FlushE=1 or FlushD=1 (once per cycle). Both wrap modulo 2^32.
- MemError stays set until reset.

## Timing
- All stall/flush/forward outputs are combinational from the current inputs and FSM state. There is no added latency: a hazard seen in cycle N is acted on at the edge ending cycle N.
- A memory access with ready in the same cycle as the request causes no stall. With ready k cycles later (k<MEM_TIMEOUT), it stalls exactly k cycles.
- Timeout: stall lasts MEM_TIMEOUT cycles. The following cycle is unstalled, and MemError=1 from the next edge.
- Reset (anytime, including mid-WAIT): state IDLE, cnt=0, MemError=0, counters=0. After reset, outputs are the combinational decode of the inputs; with all inputs 0, every output is 0.
- Simultaneous lwstall and PCSrcD: FlushD suppressed (StallD wins); branch re-resolves next cycle.

## Test plan
- Forwarding: RsE=5, WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1 -> ForwardAE=10. Then RsE=0 with matching WriteRegM=0 -> ForwardAE=00.
- Load-use: MemtoRegE=1, RtE=3, RsD=3 -> StallF=StallD=FlushE=1 for one cycle; StallCycles and FlushCycles each +1.
- Branch hazard: BranchD=1, RegWriteE=1, WriteRegE=RtD=7 -> stall one cycle. Next cycle, ForwardBD=1 with WriteRegM=7.
- Memory wait: MemReqM=1, MemReadyM low 3 cycles then high -> StallF..StallM=1 and FlushW=1 for exactly 3 cycles, FlushE=0 throughout, MemError=0.
- Timeout: MEM_TIMEOUT=4, MemReadyM never high -> 4 stall cycles, 1 release cycle, MemError=1 afterwards, re-stall if a new request arrives.
- Reset mid-WAIT at cycle 2 -> all stalls drop immediately, counters=0, MemError=0. Taken branch with PCSrcD=1 and no stall -> FlushD=1.
